// File: rtl/scan_pkg.sv
// ----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan index sequencer:
//   - state encoding of the sequencer FSM (ST_IDLE, ST_DWELL)
//   - index width / count and the "everything masked" constant
//   - idx_add: circular add on the 3-bit index space
// ----------------------------------------------------------------------------
package scan_pkg;

    localparam int          IDX_W    = 3;
    localparam int          N_IDX    = 8;
    localparam logic [7:0]  MASK_ALL = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    // Modulo-N_IDX addition; the truncation to IDX_W bits is the wrap-around.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
        return base + IDX_W'(off);
    endfunction

endpackage

// File: rtl/scan_next_idx.sv
// ----------------------------------------------------------------------------
// scan_next_idx
// Combinational circular priority search: finds the first unmasked index
// strictly after cur_i (cur_i+1, cur_i+2, ... wrapping, ending at cur_i itself).
// Ports:
//   cur_i   [2:0]  current index (search starts at cur_i+1)
//   mask_i  [7:0]  bit i = 1 -> index i is not eligible
//   nxt_o   [2:0]  first eligible index found (0 when none)
//   wraps_o        the found index is <= cur_i (search went past 7 or landed on cur_i)
//   none_o         every index is masked
// ----------------------------------------------------------------------------
module scan_next_idx
    import scan_pkg::*;
(
    input  logic [IDX_W-1:0] cur_i,
    input  logic [N_IDX-1:0] mask_i,
    output logic [IDX_W-1:0] nxt_o,
    output logic             wraps_o,
    output logic             none_o
);

    // cand[gi] is the candidate at search distance gi+1; avail[gi] says it is unmasked.
    logic [IDX_W-1:0] cand [N_IDX];
    logic [N_IDX-1:0] avail;

    generate
        for (genvar gi = 0; gi < N_IDX; gi++) begin : g_cand
            assign cand[gi]  = idx_add(cur_i, gi + 1);
            assign avail[gi] = ~mask_i[cand[gi]];
        end
    endgenerate

    // Scan from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        nxt_o = '0;
        for (int k = N_IDX - 1; k >= 0; k--) begin
            if (avail[k]) begin
                nxt_o = cand[k];
            end
        end
    end

    assign none_o  = ~|avail;
    assign wraps_o = ~none_o && (nxt_o <= cur_i);

endmodule

// File: rtl/scan_index_sequencer.sv
// ----------------------------------------------------------------------------
// scan_index_sequencer
// Generates the 3-bit select index for a 3-to-8 decoder: walks 0..7 in
// ascending circular order, skipping masked indices, holding each index for
// dwell_i+1 enabled cycles. One-shot or continuous; pause via en_i; abort_i.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   en_i            count enable (0 = hold index and dwell counter)
//   start_i         begin a scan (only looked at while idle)
//   abort_i         return to idle next cycle, no pulses
//   oneshot_i       1 = stop after one pass, 0 = loop forever
//   skip_mask_i     bit i = 1 -> skip index i
//   dwell_i         hold time minus one for each index
//   sel_o           index to the decoder
//   sel_valid_o     sel_o is meaningful
//   busy_o          a scan is in progress
//   wrap_o          1-cycle pulse when the index wraps (continuous mode)
//   done_o          1-cycle pulse at the end of a one-shot pass
// All outputs are registered.
// ----------------------------------------------------------------------------
module scan_index_sequencer
    import scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             oneshot_i,
    input  logic [N_IDX-1:0] skip_mask_i,
    input  logic [DW-1:0]    dwell_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             sel_valid_o,
    output logic             busy_o,
    output logic             wrap_o,
    output logic             done_o
);

    state_t           state_q;
    logic [IDX_W-1:0] sel_q;
    logic             sel_valid_q;
    logic             busy_q;
    logic             wrap_q;
    logic             done_q;
    logic [DW-1:0]    cnt_q;

    // Successor of the current index, used at each advance.
    logic [IDX_W-1:0] adv_nxt;
    logic             adv_wraps;
    logic             adv_none;

    // Same search from cur=7 yields the lowest unmasked index for a start.
    logic [IDX_W-1:0] first_nxt;
    logic             first_wraps;
    logic             first_none;

    scan_next_idx u_adv (
        .cur_i   (sel_q),
        .mask_i  (skip_mask_i),
        .nxt_o   (adv_nxt),
        .wraps_o (adv_wraps),
        .none_o  (adv_none)
    );

    scan_next_idx u_first (
        .cur_i   (IDX_W'(N_IDX - 1)),
        .mask_i  (skip_mask_i),
        .nxt_o   (first_nxt),
        .wraps_o (first_wraps),
        .none_o  (first_none)
    );

    // Searching from 7, any index found counts as a wrap, so first_wraps is
    // the "some index is unmasked" flag; none is folded in for clarity.
    logic start_ok_d;
    assign start_ok_d = start_i && first_wraps && !first_none;

    // Dwell counter reaching zero with en set is the advance point.
    logic advance_d;
    assign advance_d = en_i && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // Pulses default low; they are set only on the cycle that produces them.
            wrap_q <= 1'b0;
            done_q <= 1'b0;

            if (abort_i) begin
                state_q     <= ST_IDLE;
                sel_q       <= '0;
                sel_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok_d) begin
                            state_q     <= ST_DWELL;
                            sel_q       <= first_nxt;
                            sel_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            cnt_q       <= dwell_i;
                        end
                    end

                    ST_DWELL: begin
                        if (en_i && !advance_d) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (advance_d) begin
                            // A fully masked set ends the scan even in continuous mode.
                            if (adv_none || (adv_wraps && oneshot_i)) begin
                                state_q     <= ST_IDLE;
                                sel_q       <= '0;
                                sel_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                cnt_q       <= '0;
                                done_q      <= 1'b1;
                            end else begin
                                sel_q  <= adv_nxt;
                                cnt_q  <= dwell_i;
                                wrap_q <= adv_wraps;
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;
    assign busy_o      = busy_q;
    assign wrap_o      = wrap_q;
    assign done_o      = done_q;

endmodule
